// File: rtl/icache_mem_responder.sv
// I-cache miss responder: queues line-fill requests, fetches each line in BEATS memory reads, returns it in one pulse.
// Fill latency is 10 cycles with zero-wait memory; grant/data stalls stretch REQ/DATA, and requests are dropped (sticky flag) when the queue is full.
module icache_mem_responder #(
  parameter int BLOCK_ADDR_BITS = 27,
  parameter int INDEX_BITS      = 7,
  parameter int LINE_BITS       = 256,
  parameter int MEM_DATA_BITS   = 64,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [BLOCK_ADDR_BITS-1:0]          ic2memReqAddr_i,
  input  logic                                ic2memReqValid_i,
  output logic [BLOCK_ADDR_BITS-INDEX_BITS-1:0] mem2icTag_o,
  output logic [INDEX_BITS-1:0]               mem2icIndex_o,
  output logic [LINE_BITS-1:0]                mem2icData_o,
  output logic                                mem2icRespValid_o,
  output logic [31:0]                         memRdAddr_o,
  output logic                                memRdReq_o,
  input  logic                                memRdGnt_i,
  input  logic [MEM_DATA_BITS-1:0]            memRdData_i,
  input  logic                                memRdDataValid_i,
  output logic                                busy_o,
  output logic                                reqDropped_o
);
  localparam int BEATS     = LINE_BITS / MEM_DATA_BITS;
  localparam int BEAT_BITS = $clog2(BEATS);
  localparam int OFF_BITS  = $clog2(MEM_DATA_BITS / 8);
  localparam int PTR_BITS  = $clog2(FIFO_DEPTH);
  localparam logic [PTR_BITS:0]    PTR_ONE  = 1;
  localparam logic [BEAT_BITS-1:0] BEAT_ONE = 1;
  localparam logic [BEAT_BITS-1:0] BEAT_LAST = BEAT_BITS'(BEATS - 1);

  typedef enum logic [1:0] {IDLE, REQ, DATA, RESP} stateT;

  stateT                      state, stateNext;
  logic [BLOCK_ADDR_BITS-1:0] fifoMem [FIFO_DEPTH];
  logic [PTR_BITS:0]          wrPtr, rdPtr;
  logic [PTR_BITS-1:0]        tailIdx;
  logic                       fifoEmpty, fifoFull;
  logic [BLOCK_ADDR_BITS-1:0] fifoHead, fifoTail;
  logic [BLOCK_ADDR_BITS-1:0] curAddr;
  logic                       inService;
  logic [BEAT_BITS-1:0]       beatCnt;
  logic                       lastBeat;
  logic [LINE_BITS-1:0]       lineBuf, lineNext;
  logic                       isDup, push, pop, overflow;

  assign fifoEmpty = (wrPtr == rdPtr);
  assign fifoFull  = (wrPtr[PTR_BITS] != rdPtr[PTR_BITS]) &&
                     (wrPtr[PTR_BITS-1:0] == rdPtr[PTR_BITS-1:0]);
  assign tailIdx   = wrPtr[PTR_BITS-1:0] - PTR_BITS'(1);
  assign fifoHead  = fifoMem[rdPtr[PTR_BITS-1:0]];
  assign fifoTail  = fifoMem[tailIdx];
  assign lastBeat  = (beatCnt == BEAT_LAST);

  // inService covers the line being fetched and a head already popped in RESP but not yet started.
  assign isDup    = (inService && ic2memReqAddr_i == curAddr) ||
                    (!fifoEmpty && ic2memReqAddr_i == fifoTail);
  assign push     = ic2memReqValid_i && !isDup && (!fifoFull || pop);
  assign overflow = ic2memReqValid_i && !isDup && fifoFull && !pop;

  assign memRdAddr_o = (state == REQ) ? 32'({curAddr, beatCnt, {OFF_BITS{1'b0}}}) : 32'd0;
  assign busy_o      = !fifoEmpty || (state != IDLE) || inService;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= stateNext;
  end

  always_comb begin
    stateNext         = state;
    memRdReq_o        = 1'b0;
    mem2icRespValid_o = 1'b0;
    pop               = 1'b0;
    lineNext          = lineBuf;
    lineNext[beatCnt*MEM_DATA_BITS +: MEM_DATA_BITS] = memRdData_i;
    case (state)
      IDLE: begin
        pop = !inService && !fifoEmpty;
        if (inService || !fifoEmpty) stateNext = REQ;
      end
      REQ: begin
        memRdReq_o = 1'b1;
        if (memRdGnt_i) stateNext = DATA;
      end
      DATA: begin
        if (memRdDataValid_i) stateNext = lastBeat ? RESP : REQ;
      end
      RESP: begin
        mem2icRespValid_o = 1'b1;
        // Popping here frees a slot for a same-cycle push and preloads the next line.
        pop       = !fifoEmpty;
        stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) fifoMem[wrPtr[PTR_BITS-1:0]] <= ic2memReqAddr_i;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wrPtr         <= '0;
      rdPtr         <= '0;
      curAddr       <= '0;
      inService     <= 1'b0;
      beatCnt       <= '0;
      lineBuf       <= '0;
      mem2icTag_o   <= '0;
      mem2icIndex_o <= '0;
      mem2icData_o  <= '0;
      reqDropped_o  <= 1'b0;
    end else begin
      if (push) wrPtr <= wrPtr + PTR_ONE;
      if (pop) begin
        rdPtr     <= rdPtr + PTR_ONE;
        curAddr   <= fifoHead;
        inService <= 1'b1;
      end else if (state == RESP) begin
        inService <= 1'b0;
      end
      if (state == IDLE || state == RESP) begin
        beatCnt <= '0;
      end else if (state == DATA && memRdDataValid_i && !lastBeat) begin
        beatCnt <= beatCnt + BEAT_ONE;
      end
      if (state == DATA && memRdDataValid_i) begin
        lineBuf <= lineNext;
        if (lastBeat) begin
          mem2icTag_o   <= curAddr[BLOCK_ADDR_BITS-1:INDEX_BITS];
          mem2icIndex_o <= curAddr[INDEX_BITS-1:0];
          mem2icData_o  <= lineNext;
        end
      end
      if (overflow) reqDropped_o <= 1'b1;
    end
  end
endmodule

// File: tb/tb_icache_mem_responder.sv
// Directed bench for icache_mem_responder with a small programmable backing-memory model.
module tb_icache_mem_responder;
  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [26:0]  reqAddr = '0;
  logic         reqValid = 1'b0;
  logic [19:0]  respTag;
  logic [6:0]   respIndex;
  logic [255:0] respData;
  logic         respValid;
  logic [31:0]  memRdAddr;
  logic         memRdReq;
  logic         memRdGnt;
  logic [63:0]  memRdData;
  logic         memRdDataValid;
  logic         busy;
  logic         reqDropped;

  int checks = 0;
  int failures = 0;

  bit gntHold = 1'b0;
  bit plainData = 1'b0;
  int gntStall[4] = '{0, 0, 0, 0};
  int dataDelay[4] = '{0, 0, 0, 0};

  always #5 clk = ~clk;

  icache_mem_responder dut (
    .clk               (clk),
    .reset             (reset),
    .ic2memReqAddr_i   (reqAddr),
    .ic2memReqValid_i  (reqValid),
    .mem2icTag_o       (respTag),
    .mem2icIndex_o     (respIndex),
    .mem2icData_o      (respData),
    .mem2icRespValid_o (respValid),
    .memRdAddr_o       (memRdAddr),
    .memRdReq_o        (memRdReq),
    .memRdGnt_i        (memRdGnt),
    .memRdData_i       (memRdData),
    .memRdDataValid_i  (memRdDataValid),
    .busy_o            (busy),
    .reqDropped_o      (reqDropped)
  );

  function automatic logic [63:0] beatData(input logic [31:0] a);
    logic [3:0] n;
    n = 4'(a[4:3]) + 4'd1;
    if (plainData) return {16{n}};
    return {a, ~a};
  endfunction

  function automatic logic [255:0] expLine(input logic [26:0] blk);
    logic [255:0] l;
    l = '0;
    for (int b = 0; b < 4; b++) l[b*64 +: 64] = beatData({blk, 2'(b), 3'b000});
    return l;
  endfunction

  // Memory model: grant decided each cycle from the live request, data delivered after the programmed delay.
  initial begin : memModel
    int stallCnt;
    bit pending;
    int pendWait;
    int beat;
    logic [31:0] pendAddr;
    stallCnt = 0; pending = 0; pendWait = 0; pendAddr = '0; beat = 0;
    memRdGnt = 1'b0; memRdDataValid = 1'b0; memRdData = '0;
    forever begin
      @(posedge clk); #1;
      memRdDataValid = 1'b0;
      if (pending) begin
        if (pendWait == 0) begin
          memRdDataValid = 1'b1;
          memRdData = beatData(pendAddr);
          pending = 0;
        end else begin
          pendWait--;
        end
      end
      memRdGnt = 1'b0;
      if (memRdReq && !gntHold) begin
        beat = int'(memRdAddr[4:3]);
        if (stallCnt < gntStall[beat]) begin
          stallCnt++;
        end else begin
          memRdGnt = 1'b1;
          stallCnt = 0;
          pending = 1;
          pendAddr = memRdAddr;
          pendWait = dataDelay[beat];
        end
      end
    end
  end

  task automatic doReset();
    @(posedge clk); #1;
    reset = 1'b1; reqValid = 1'b0; gntHold = 1'b0; plainData = 1'b0;
    for (int i = 0; i < 4; i++) begin gntStall[i] = 0; dataDelay[i] = 0; end
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++; if ({respValid, memRdReq, busy, reqDropped} !== 4'b0) begin failures++;
      $display("FAIL reset_ctrl got=%b exp=0000", {respValid, memRdReq, busy, reqDropped}); end
    checks++; if (memRdAddr !== 32'h0) begin failures++; $display("FAIL reset_addr got=%h exp=0", memRdAddr); end
    checks++; if ({respTag, respIndex} !== 27'h0) begin failures++;
      $display("FAIL reset_tagidx got=%h exp=0", {respTag, respIndex}); end
    checks++; if (respData !== 256'h0) begin failures++; $display("FAIL reset_data got=%h exp=0", respData); end
  endtask

  task automatic test_single_fill();
    logic [31:0]  gAddr[4];
    logic [31:0]  expAddr[4];
    int nGnt, nResp, respCyc;
    logic [19:0]  tag;
    logic [6:0]   idx;
    logic [255:0] data;
    expAddr = '{32'h2460, 32'h2468, 32'h2470, 32'h2478};
    nGnt = 0; nResp = 0; respCyc = -1; tag = '0; idx = '0; data = '0;
    for (int i = 0; i < 4; i++) gAddr[i] = '0;
    doReset();
    plainData = 1'b1;
    for (int c = 0; c < 16; c++) begin
      @(posedge clk); #1;
      reqValid = (c == 0); reqAddr = 27'h0000123;
      @(negedge clk);
      if (memRdReq && memRdGnt) begin
        if (nGnt < 4) gAddr[nGnt] = memRdAddr;
        nGnt++;
      end
      if (respValid) begin nResp++; respCyc = c; tag = respTag; idx = respIndex; data = respData; end
    end
    checks++; if (nGnt !== 4) begin failures++; $display("FAIL single_beats got=%0d exp=4", nGnt); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (gAddr[i] !== expAddr[i]) begin failures++;
        $display("FAIL single_addr%0d got=%h exp=%h", i, gAddr[i], expAddr[i]); end
    end
    checks++; if (nResp !== 1) begin failures++; $display("FAIL single_nresp got=%0d exp=1", nResp); end
    checks++; if (respCyc !== 10) begin failures++; $display("FAIL single_cycle got=%0d exp=10", respCyc); end
    checks++; if (tag !== 20'h00002) begin failures++; $display("FAIL single_tag got=%h exp=00002", tag); end
    checks++; if (idx !== 7'h23) begin failures++; $display("FAIL single_index got=%h exp=23", idx); end
    checks++; if (data !== 256'h4444444444444444_3333333333333333_2222222222222222_1111111111111111) begin
      failures++; $display("FAIL single_data got=%h", data); end
    checks++; if (respTag !== 20'h00002) begin failures++; $display("FAIL single_tag_hold got=%h exp=00002", respTag); end
  endtask

  task automatic test_coalesce();
    logic [26:0]  blk;
    int nGnt, nResp, respCyc;
    logic busy10, busy11;
    logic [255:0] data;
    blk = 27'h0ABCDEF; nGnt = 0; nResp = 0; respCyc = -1; busy10 = 0; busy11 = 1; data = '0;
    doReset();
    for (int c = 0; c < 16; c++) begin
      @(posedge clk); #1;
      reqValid = (c < 3); reqAddr = blk;
      @(negedge clk);
      if (memRdReq && memRdGnt) nGnt++;
      if (respValid) begin nResp++; respCyc = c; data = respData; end
      if (c == 10) busy10 = busy;
      if (c == 11) busy11 = busy;
    end
    checks++; if (nGnt !== 4) begin failures++; $display("FAIL coalesce_beats got=%0d exp=4", nGnt); end
    checks++; if (nResp !== 1) begin failures++; $display("FAIL coalesce_nresp got=%0d exp=1", nResp); end
    checks++; if (respCyc !== 10) begin failures++; $display("FAIL coalesce_cycle got=%0d exp=10", respCyc); end
    checks++; if (data !== expLine(blk)) begin failures++; $display("FAIL coalesce_data got=%h", data); end
    checks++; if (busy10 !== 1'b1) begin failures++; $display("FAIL coalesce_busy_resp got=%b exp=1", busy10); end
    checks++; if (busy11 !== 1'b0) begin failures++; $display("FAIL coalesce_busy_after got=%b exp=0", busy11); end
  endtask

  task automatic test_overflow();
    logic [26:0]  blk[6];
    logic [26:0]  rTi[8];
    logic [255:0] rData[8];
    int rCyc[8];
    int nResp;
    nResp = 0;
    for (int i = 0; i < 6; i++) blk[i] = 27'h1234567 + 27'(i) * 27'h81;
    for (int i = 0; i < 8; i++) begin rTi[i] = '0; rData[i] = '0; rCyc[i] = 0; end
    doReset();
    gntHold = 1'b1;
    for (int c = 0; c < 76; c++) begin
      @(posedge clk); #1;
      reqValid = (c < 6); reqAddr = blk[c < 6 ? c : 5];
      if (c == 9) gntHold = 1'b0;
      @(negedge clk);
      if (c == 5) begin checks++; if (reqDropped !== 1'b0) begin failures++;
        $display("FAIL ovf_dropped_c5 got=%b exp=0", reqDropped); end end
      if (c == 6) begin checks++; if (reqDropped !== 1'b1) begin failures++;
        $display("FAIL ovf_dropped_c6 got=%b exp=1", reqDropped); end end
      if (respValid) begin
        if (nResp < 8) begin rTi[nResp] = {respTag, respIndex}; rData[nResp] = respData; rCyc[nResp] = c; end
        nResp++;
      end
    end
    checks++; if (nResp !== 5) begin failures++; $display("FAIL ovf_nresp got=%0d exp=5", nResp); end
    for (int i = 0; i < 5; i++) begin
      checks++; if (rTi[i] !== blk[i]) begin failures++;
        $display("FAIL ovf_order%0d got=%h exp=%h", i, rTi[i], blk[i]); end
      checks++; if (rData[i] !== expLine(blk[i])) begin failures++; $display("FAIL ovf_data%0d got=%h", i, rData[i]); end
      if (i > 0) begin
        checks++; if (rCyc[i] - rCyc[i-1] !== 10) begin failures++;
          $display("FAIL ovf_spacing%0d got=%0d exp=10", i, rCyc[i] - rCyc[i-1]); end
      end
    end
    checks++; if (reqDropped !== 1'b1) begin failures++; $display("FAIL ovf_sticky got=%b exp=1", reqDropped); end
  endtask

  task automatic test_backpressure();
    logic [26:0]  blk;
    int nResp, respCyc;
    logic [255:0] data;
    blk = 27'h0000456; nResp = 0; respCyc = -1; data = '0;
    doReset();
    gntStall[2] = 3; dataDelay[3] = 2;
    for (int c = 0; c < 22; c++) begin
      @(posedge clk); #1;
      reqValid = (c == 0); reqAddr = blk;
      @(negedge clk);
      if (c == 1) begin checks++; if (reqDropped !== 1'b0) begin failures++;
        $display("FAIL bp_dropped_cleared got=%b exp=0", reqDropped); end end
      if (c >= 6 && c <= 9) begin
        checks++; if ({memRdReq, memRdAddr} !== {1'b1, 32'h8AD0}) begin failures++;
          $display("FAIL bp_hold_c%0d got=%b/%h exp=1/00008ad0", c, memRdReq, memRdAddr); end
      end
      if (respValid) begin nResp++; respCyc = c; data = respData; end
    end
    checks++; if (nResp !== 1) begin failures++; $display("FAIL bp_nresp got=%0d exp=1", nResp); end
    checks++; if (respCyc !== 15) begin failures++; $display("FAIL bp_cycle got=%0d exp=15", respCyc); end
    checks++; if (data !== expLine(blk)) begin failures++; $display("FAIL bp_data got=%h", data); end
  endtask

  task automatic test_reset_mid_fill();
    logic [26:0]  blk, blk2;
    int nEarly, nResp, respCyc;
    logic [26:0]  ti;
    logic [255:0] data;
    blk = 27'h0000789; blk2 = 27'h0000A5B; nEarly = 0; nResp = 0; respCyc = -1; ti = '0; data = '0;
    doReset();
    dataDelay[1] = 2;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      reqValid = (c == 0) || (c == 22); reqAddr = (c < 22) ? blk : blk2;
      reset = (c == 5);
      if (c == 10) dataDelay[1] = 0;
      @(negedge clk);
      if (c == 6) begin
        checks++; if ({respValid, memRdReq, busy, reqDropped} !== 4'b0) begin failures++;
          $display("FAIL rmid_ctrl got=%b exp=0000", {respValid, memRdReq, busy, reqDropped}); end
        checks++; if (memRdAddr !== 32'h0) begin failures++; $display("FAIL rmid_addr got=%h exp=0", memRdAddr); end
        checks++; if ({respTag, respIndex} !== 27'h0) begin failures++;
          $display("FAIL rmid_tagidx got=%h exp=0", {respTag, respIndex}); end
        checks++; if (respData !== 256'h0) begin failures++; $display("FAIL rmid_data got=%h exp=0", respData); end
      end
      if (respValid) begin
        if (c < 22) nEarly++;
        else begin nResp++; respCyc = c; ti = {respTag, respIndex}; data = respData; end
      end
    end
    checks++; if (nEarly !== 0) begin failures++; $display("FAIL rmid_ghost_resp got=%0d exp=0", nEarly); end
    checks++; if (nResp !== 1) begin failures++; $display("FAIL rmid_nresp got=%0d exp=1", nResp); end
    checks++; if (respCyc !== 32) begin failures++; $display("FAIL rmid_cycle got=%0d exp=32", respCyc); end
    checks++; if (ti !== blk2) begin failures++; $display("FAIL rmid_tagidx2 got=%h exp=%h", ti, blk2); end
    checks++; if (data !== expLine(blk2)) begin failures++; $display("FAIL rmid_data2 got=%h", data); end
  endtask

  task automatic test_push_full_resp();
    logic [26:0] blk[6];
    logic [26:0] rTi[8];
    int rCyc[8];
    int nResp;
    nResp = 0;
    for (int i = 0; i < 6; i++) blk[i] = 27'h3000000 + 27'(i) * 27'h0C3;
    for (int i = 0; i < 8; i++) begin rTi[i] = '0; rCyc[i] = 0; end
    doReset();
    for (int c = 0; c < 70; c++) begin
      @(posedge clk); #1;
      reqValid = (c < 5) || (c == 10); reqAddr = (c < 5) ? blk[c] : blk[5];
      @(negedge clk);
      if (c == 10) begin checks++; if (respValid !== 1'b1) begin failures++;
        $display("FAIL pfull_resp_c10 got=%b exp=1", respValid); end end
      if (c == 11) begin checks++; if (reqDropped !== 1'b0) begin failures++;
        $display("FAIL pfull_dropped got=%b exp=0", reqDropped); end end
      if (respValid) begin
        if (nResp < 8) begin rTi[nResp] = {respTag, respIndex}; rCyc[nResp] = c; end
        nResp++;
      end
    end
    checks++; if (nResp !== 6) begin failures++; $display("FAIL pfull_nresp got=%0d exp=6", nResp); end
    for (int i = 0; i < 6; i++) begin
      checks++; if (rTi[i] !== blk[i]) begin failures++;
        $display("FAIL pfull_order%0d got=%h exp=%h", i, rTi[i], blk[i]); end
      checks++; if (rCyc[i] !== 10 + 10 * i) begin failures++;
        $display("FAIL pfull_cycle%0d got=%0d exp=%0d", i, rCyc[i], 10 + 10 * i); end
    end
    checks++; if (reqDropped !== 1'b0) begin failures++; $display("FAIL pfull_sticky got=%b exp=0", reqDropped); end
  endtask

  initial begin
    test_reset();
    test_single_fill();
    test_coalesce();
    test_overflow();
    test_backpressure();
    test_reset_mid_fill();
    test_push_full_resp();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/icache_mem_responder.md
# icache_mem_responder

Memory-side responder for the instruction-cache miss interface. It accepts one-cycle line-fill requests (block address plus valid) from the I-cache and queues them in a small FIFO. For each request it fetches the line from a word-wide backing-memory read port in sequential beats, assembles the full line, and returns it to the I-cache as a one-cycle response carrying tag, index and data. It sits between the fetch-stage cache and the L2/memory model, at the opposite end of the cache's request/response handshake.

## Interface
- BLOCK_ADDR_BITS, 27, line block-address width (32-bit PC, 32-byte line)
- INDEX_BITS, 7, cache index width; TAG_BITS = BLOCK_ADDR_BITS-INDEX_BITS (20)
- LINE_BITS, 256, bits per cache line
- MEM_DATA_BITS, 64, backing-memory beat width; BEATS = LINE_BITS/MEM_DATA_BITS (4)
- FIFO_DEPTH, 4, request queue entries (power of 2)
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- ic2memReqAddr_i  in  BLOCK_ADDR_BITS  requested line block address
- ic2memReqValid_i  in  1  request strobe; each high cycle is a candidate request
- mem2icTag_o  out  TAG_BITS  tag of returned line
- mem2icIndex_o  out  INDEX_BITS  index of returned line
- mem2icData_o  out  LINE_BITS  returned line data
- mem2icRespValid_o  out  1  one-cycle response pulse
- memRdAddr_o  out  32  byte address of current beat
- memRdReq_o  out  1  beat read request
- memRdGnt_i  in  1  memory accepted the beat request
- memRdData_i  in  MEM_DATA_BITS  beat data
- memRdDataValid_i  in  1  beat data valid
- busy_o  out  1  FIFO non-empty or FSM not IDLE
- reqDropped_o  out  1  sticky: a request was lost to overflow; cleared only by reset

## Operation
- Request intake: a request is pushed when valid is high, the FIFO is not full (push is also permitted in a RESP cycle, since the pop frees a slot), and the address differs from both the entry in service (while the FSM is not IDLE) and the FIFO tail entry. A matching address is dropped silently. An overflow drop sets reqDropped_o.
- FSM states: IDLE, REQ, DATA, RESP.
- IDLE: when the FIFO is non-empty, load head into curAddr, set beatCnt=0, and go to REQ.
- REQ: drive memRdReq_o=1 and memRdAddr_o={curAddr, beatCnt[log2 BEATS-1:0], 3'b000}. Hold until memRdGnt_i, then go to DATA.
- DATA: on memRdDataValid_i, write the beat into line buffer bits [beatCnt*MEM_DATA_BITS +: MEM_DATA_BITS] (beat 0 = LSBs). If this is the last beat, go to RESP. Otherwise increment beatCnt and go to REQ.
- memRdDataValid_i is ignored outside DATA; memory must return data at least 1 cycle after grant.
- RESP: for one cycle, drive mem2icRespValid_o=1 with tag=curAddr[BLOCK_ADDR_BITS-1:INDEX_BITS], index=curAddr[INDEX_BITS-1:0], data=line buffer. Pop the FIFO and go to IDLE.
- Tag, index and data outputs are registered and hold their values until the next RESP.
- FIFO pointers carry one extra wrap bit: full when the pointers differ only in MSB, empty when equal.

## Timing
- Reset values: all outputs 0, FIFO empty, state IDLE, beatCnt 0, line buffer 0.
- Reset mid-fill abandons the fill and clears the queue; no response is issued for it.
- Request pushed at cycle 0 → IDLE sees it in cycle 1 → REQ in cycle 2.
- Each beat with same-cycle grant and data one cycle later takes 2 cycles. With BEATS=4, mem2icRespValid_o pulses in cycle 10.
- Back-to-back requests: the next REQ starts at RESP+2 (RESP→IDLE→REQ).
- Grant stalls extend REQ, and data stalls extend DATA, cycle for cycle.
- Responses return in request order; at most one response every BEATS*2+2 cycles.

## Test plan
- Single fill: req addr 0x0000123 at cycle 0, zero-wait memory returning data 0x1111…, 0x2222…, 0x3333…, 0x4444… → memRdAddr_o = 0x2460, 0x2468, 0x2470, 0x2478. RespValid pulses once at cycle 10 with index 0x23, tag 0x00002, data {0x4444…, 0x3333…, 0x2222…, 0x1111…}.
- Coalescing: same address strobed 3 consecutive cycles → exactly one fill and one response; busy_o falls after RESP.
- Overflow: 6 distinct requests in consecutive cycles with grant held low → 5 accepted (1 in service plus 4 queued), reqDropped_o=1 from cycle 6. On grant release, 5 in-order responses follow.
- Backpressure: memRdGnt_i low for 3 cycles on beat 2 and data delayed by 2 cycles on beat 3 → memRdAddr_o stable while held, correct line, response 5 cycles later than nominal.
- Reset mid-fill: reset asserted during DATA beat 1 → next cycle all outputs 0 and FIFO empty; a late memRdDataValid_i causes no response. A new request afterwards completes normally.
- Push on full during RESP: FIFO full, new distinct request coincident with RESP → request accepted, reqDropped_o stays 0.
